// File: rtl/ysyx_23060208_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter, one whole transaction per grant.
// Optional macro ARB_RR_EN: round-robin IFU/LSU arbitration with a last-grant pointer instead of fixed priority.
module ysyx_23060208_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU read port
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read port
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // LSU write port
  input  logic [DATA_WIDTH-1:0] lsu_awaddr,
  input  logic                  lsu_awvalid,
  output logic                  lsu_awready,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [STRB_WIDTH-1:0] lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  // slave read side
  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  // slave write side
  output logic [DATA_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic                  arb_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;
  state_t lsu_grant_s;
  logic   ar_done_r;
  logic   aw_done_r;
  logic   w_done_r;
  logic   wr_resp_s;
  logic   ar_hs_s;
  logic   aw_hs_s;
  logic   w_hs_s;
  logic   r_hs_s;
  logic   b_hs_s;

  assign ar_hs_s     = s_arvalid & s_arready;
  assign aw_hs_s     = s_awvalid & s_awready;
  assign w_hs_s      = s_wvalid & s_wready;
  assign r_hs_s      = s_rvalid & s_rready;
  assign b_hs_s      = s_bvalid & s_bready;
  assign wr_resp_s   = aw_done_r & w_done_r;
  assign lsu_grant_s = lsu_awvalid ? WR_LSU : RD_LSU;
  assign arb_busy    = (state_r != IDLE);

`ifdef ARB_RR_EN
  logic last_ifu_r;

  // Last-grant pointer: records which master completed most recently.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ifu_r <= 1'b1;
    end else if (state_r == RD_IFU && r_hs_s) begin
      last_ifu_r <= 1'b1;
    end else if ((state_r == RD_LSU && r_hs_s) || (state_r == WR_LSU && b_hs_s)) begin
      last_ifu_r <= 1'b0;
    end else begin
      last_ifu_r <= last_ifu_r;
    end
  end
`endif

  // Next-state logic: arbitration in IDLE, completion detection elsewhere.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
`ifdef ARB_RR_EN
        // LSU wins only when IFU is idle or was the last master served
        if ((lsu_awvalid | lsu_arvalid) && (!ifu_arvalid || last_ifu_r)) begin
          state_s = lsu_grant_s;
        end else if (ifu_arvalid) begin
          state_s = RD_IFU;
        end else begin
          state_s = IDLE;
        end
`else
        if (lsu_awvalid | lsu_arvalid) begin
          state_s = lsu_grant_s;
        end else if (ifu_arvalid) begin
          state_s = RD_IFU;
        end else begin
          state_s = IDLE;
        end
`endif
      end
      RD_IFU, RD_LSU: state_s = r_hs_s ? IDLE : state_r;
      WR_LSU:         state_s = b_hs_s ? IDLE : state_r;
      default:        state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Per-channel done flags; cleared whenever the transaction ends.
  always_ff @(posedge clk) begin
    if (rst || state_s == IDLE) begin
      ar_done_r <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      ar_done_r <= ar_done_r | ar_hs_s;
      aw_done_r <= aw_done_r | aw_hs_s;
      w_done_r  <= w_done_r | w_hs_s;
    end
  end

  // Channel routing for the granted master; everything else held at zero.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = 2'b00;
    lsu_bvalid  = 1'b0;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    case (state_r)
      RD_IFU: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid & ~ar_done_r;
        ifu_arready = s_arready & ~ar_done_r;
        ifu_rvalid  = s_rvalid;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        s_rready    = ifu_rready;
      end
      RD_LSU: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid & ~ar_done_r;
        lsu_arready = s_arready & ~ar_done_r;
        lsu_rvalid  = s_rvalid;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        s_rready    = lsu_rready;
      end
      WR_LSU: begin
        s_awaddr    = lsu_awaddr;
        s_awvalid   = lsu_awvalid & ~aw_done_r;
        lsu_awready = s_awready & ~aw_done_r;
        s_wdata     = lsu_wdata;
        s_wstrb     = lsu_wstrb;
        s_wvalid    = lsu_wvalid & ~w_done_r;
        lsu_wready  = s_wready & ~w_done_r;
        lsu_bvalid  = s_bvalid & wr_resp_s;
        lsu_bresp   = s_bresp;
        s_bready    = lsu_bready & wr_resp_s;
      end
      IDLE: begin
        s_arvalid = 1'b0;
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Directed bench for ysyx_23060208_mem_arbiter; the bench plays both masters and the slave.
module tb_ysyx_23060208_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, s_rdata;
  logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
  logic        lsu_awvalid, lsu_wvalid, lsu_bready;
  logic [2:0]  lsu_wstrb;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [1:0]  s_rresp, s_bresp;

  logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
  logic        lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
  logic [2:0]  s_wstrb;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, arb_busy;

  int total = 0;
  int bad   = 0;

  ysyx_23060208_mem_arbiter #(.DATA_WIDTH(32), .STRB_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input string tag);
    int n = 0;
    while (!s_arvalid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, s_arvalid, 1'b1);
  endtask

  // Slave side of one read; the master m (0=IFU, 1=LSU) already holds arvalid.
  task automatic rd_txn(input bit m, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int dly);
    wait_ar("ar_grant");
    chk("s_araddr", s_araddr, addr);
    repeat (dly) begin
      chk("ar_held", m ? lsu_arready : ifu_arready, 1'b0);
      tick();
    end
    s_arready = 1'b1;
    #1;
    chk("m_arready", m ? lsu_arready : ifu_arready, 1'b1);
    chk("o_arready", m ? ifu_arready : lsu_arready, 1'b0);
    tick();
    s_arready = 1'b0;
    if (m) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    #1;
    chk("ar_done_gate", s_arvalid, 1'b0);
    s_rvalid = 1'b1;
    s_rdata  = data;
    s_rresp  = resp;
    if (m) lsu_rready = 1'b1; else ifu_rready = 1'b1;
    #1;
    chk("m_rvalid", m ? lsu_rvalid : ifu_rvalid, 1'b1);
    chk("m_rdata", m ? lsu_rdata : ifu_rdata, data);
    chk("m_rresp", m ? lsu_rresp : ifu_rresp, resp);
    chk("o_rvalid", m ? ifu_rvalid : lsu_rvalid, 1'b0);
    chk("s_rready", s_rready, 1'b1);
    tick();
    s_rvalid = 1'b0;
    s_rdata  = 32'h0;
    s_rresp  = 2'b00;
    lsu_rready = 1'b0;
    ifu_rready = 1'b0;
    #1;
    chk("idle_after_r", arb_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ifu_araddr = 32'h0; lsu_araddr = 32'h0; lsu_awaddr = 32'h0; lsu_wdata = 32'h0;
    ifu_arvalid = 1'b0; ifu_rready = 1'b0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_bready = 1'b0; lsu_wstrb = 3'b000;
    s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    s_rdata = 32'h0; s_rresp = 2'b00; s_bresp = 2'b00;
    tick();
    ifu_arvalid = 1'b1;
    tick();
    chk("rst_busy", arb_busy, 1'b0);
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_ifu_arready", ifu_arready, 1'b0);
    ifu_arvalid = 1'b0;
    rst = 1'b0;
    tick();

    // IFU read alone, with one-cycle arbitration latency observed in IDLE
    ifu_araddr  = 32'h8000_0000;
    ifu_arvalid = 1'b1;
    s_arready   = 1'b1;
    #1;
    chk("idle_no_arvalid", s_arvalid, 1'b0);
    chk("idle_no_arready", ifu_arready, 1'b0);
    s_arready = 1'b0;
    tick();
    chk("rd_ifu_busy", arb_busy, 1'b1);
    chk("rd_ifu_lsu_arready", lsu_arready, 1'b0);
    rd_txn(1'b0, 32'h8000_0000, 32'h0000_0413, 2'b00, 2);
    chk("ifu_alone_lsu_rvalid", lsu_rvalid, 1'b0);

    // Contention: LSU first, IFU after the LSU R handshake
    ifu_arvalid = 1'b1;
    lsu_araddr  = 32'h8000_0100;
    lsu_arvalid = 1'b1;
    tick();
    rd_txn(1'b1, 32'h8000_0100, 32'h1122_3344, 2'b00, 1);
    rd_txn(1'b0, 32'h8000_0000, 32'h0000_0513, 2'b00, 0);

    // LSU alone, then contention again: policy-dependent winner
    lsu_araddr  = 32'h8000_0104;
    lsu_arvalid = 1'b1;
    rd_txn(1'b1, 32'h8000_0104, 32'h5555_AAAA, 2'b00, 0);
    ifu_araddr  = 32'h8000_0004;
    ifu_arvalid = 1'b1;
    lsu_araddr  = 32'h8000_0108;
    lsu_arvalid = 1'b1;
`ifdef ARB_RR_EN
    rd_txn(1'b0, 32'h8000_0004, 32'h0000_0613, 2'b00, 0);
    rd_txn(1'b1, 32'h8000_0108, 32'h0BAD_F00D, 2'b00, 0);
`else
    rd_txn(1'b1, 32'h8000_0108, 32'h0BAD_F00D, 2'b00, 0);
    rd_txn(1'b0, 32'h8000_0004, 32'h0000_0613, 2'b00, 0);
`endif

    // Store with W presented before AW; W handshakes first
    lsu_wdata  = 32'hDEAD_BEEF;
    lsu_wstrb  = 3'b100;
    lsu_wvalid = 1'b1;
    s_wready   = 1'b1;
    tick();
    chk("w_only_idle", arb_busy, 1'b0);
    chk("w_only_s_wvalid", s_wvalid, 1'b0);
    tick();
    lsu_awaddr  = 32'h8000_0200;
    lsu_awvalid = 1'b1;
    tick();
    chk("wr_s_wvalid", s_wvalid, 1'b1);
    chk("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_s_wstrb", s_wstrb, 3'b100);
    chk("wr_lsu_wready", lsu_wready, 1'b1);
    chk("wr_s_awvalid", s_awvalid, 1'b1);
    chk("wr_s_awaddr", s_awaddr, 32'h8000_0200);
    chk("wr_awready_low", lsu_awready, 1'b0);
    tick();
    lsu_wvalid = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b1;
    lsu_bready = 1'b1;
    #1;
    chk("w_done_gate", s_wvalid, 1'b0);
    chk("b_gated_bvalid", lsu_bvalid, 1'b0);
    chk("b_gated_bready", s_bready, 1'b0);
    s_awready = 1'b1;
    #1;
    chk("wr_lsu_awready", lsu_awready, 1'b1);
    tick();
    lsu_awvalid = 1'b0;
    s_awready   = 1'b0;
    #1;
    chk("b_lsu_bvalid", lsu_bvalid, 1'b1);
    chk("b_lsu_bresp", lsu_bresp, 2'b00);
    chk("b_s_bready", s_bready, 1'b1);
    tick();
    s_bvalid = 1'b0;
    lsu_bready = 1'b0;
    chk("idle_after_b", arb_busy, 1'b0);

    // LSU AW and AR together: write first, read after B
    lsu_awaddr  = 32'h8000_0300;
    lsu_awvalid = 1'b1;
    lsu_wdata   = 32'h0000_00FF;
    lsu_wstrb   = 3'b000;
    lsu_wvalid  = 1'b1;
    lsu_araddr  = 32'h8000_0400;
    lsu_arvalid = 1'b1;
    tick();
    chk("aw_ar_s_awvalid", s_awvalid, 1'b1);
    chk("aw_ar_s_arvalid", s_arvalid, 1'b0);
    s_awready = 1'b1;
    s_wready  = 1'b1;
    tick();
    s_awready = 1'b0;
    s_wready  = 1'b0;
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    s_bvalid   = 1'b1;
    s_bresp    = 2'b00;
    lsu_bready = 1'b1;
    #1;
    chk("aw_ar_bvalid", lsu_bvalid, 1'b1);
    chk("aw_ar_no_read", s_arvalid, 1'b0);
    tick();
    s_bvalid = 1'b0;
    lsu_bready = 1'b0;
    rd_txn(1'b1, 32'h8000_0400, 32'hCAFE_0001, 2'b00, 0);

    // Error response still ends the transaction
    ifu_araddr  = 32'h8000_0008;
    ifu_arvalid = 1'b1;
    rd_txn(1'b0, 32'h8000_0008, 32'h0000_0000, 2'b10, 1);

    // Reset in RD_LSU after AR handshake abandons the read
    lsu_araddr  = 32'h8000_0500;
    lsu_arvalid = 1'b1;
    wait_ar("rst_ar_grant");
    s_arready = 1'b1;
    tick();
    s_arready   = 1'b0;
    lsu_arvalid = 1'b0;
    lsu_rready  = 1'b1;
    #1;
    chk("pre_rst_busy", arb_busy, 1'b1);
    chk("pre_rst_s_rready", s_rready, 1'b1);
    rst = 1'b1;
    s_arready = 1'b1;
    tick();
    chk("post_rst_busy", arb_busy, 1'b0);
    chk("post_rst_s_rready", s_rready, 1'b0);
    chk("post_rst_lsu_arready", lsu_arready, 1'b0);
    rst = 1'b0;
    s_arready = 1'b0;
    lsu_rready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
Name: ysyx_23060208_mem_arbiter

Overview:
Two-master, one-slave AXI-lite arbiter sharing the single memory port between the IFU fetch path (read-only) and the EXU load/store path (read and write). Sits between the core and the SRAM/bus model. Grants one whole transaction at a time (AR→R or AW+W→B) and routes all channels of the granted master, so IFU and EXU can no longer hold separate memory models.

Parameters:
DATA_WIDTH, 32, address/data width
STRB_WIDTH, 3, width of the size-encoded wstrb field, passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  reset
ifu_araddr  in  DATA_WIDTH  IFU read address
ifu_arvalid  in  1  IFU AR valid
ifu_arready  out  1  IFU AR ready
ifu_rdata  out  DATA_WIDTH  IFU read data
ifu_rresp  out  2  IFU read response
ifu_rvalid  out  1  IFU R valid
ifu_rready  in  1  IFU R ready
lsu_araddr/arvalid/arready, lsu_rdata/rresp/rvalid/rready  same as IFU set, EXU side
lsu_awaddr  in  DATA_WIDTH  store address
lsu_awvalid  in  1 / lsu_awready  out  1  AW handshake
lsu_wdata  in  DATA_WIDTH / lsu_wstrb  in  STRB_WIDTH  store data, size code
lsu_wvalid  in  1 / lsu_wready  out  1  W handshake
lsu_bresp  out  2 / lsu_bvalid  out  1 / lsu_bready  in  1  B channel
s_araddr, s_arvalid(out), s_arready(in), s_rdata(in), s_rresp(in), s_rvalid(in), s_rready(out)  slave read side
s_awaddr, s_awvalid(out), s_awready(in), s_wdata, s_wstrb, s_wvalid(out), s_wready(in), s_bresp(in), s_bvalid(in), s_bready(out)  slave write side
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- rst: synchronous, active-high; clock clk. On reset: state=IDLE, all done flags 0, every valid/ready output 0, arb_busy=0; any in-flight transaction is abandoned.
- States: IDLE, RD_IFU, RD_LSU, WR_LSU (registered).
- IDLE: all master readies 0, all slave valids 0. Fixed priority sampled each cycle: lsu_awvalid → WR_LSU; else lsu_arvalid → RD_LSU; else ifu_arvalid → RD_IFU; else stay. Minimum one-cycle arbitration latency: no AR/AW accepted in the cycle the request first appears in IDLE.
- RD_x: s_araddr=x_araddr; s_arvalid=x_arvalid & ~ar_done; x_arready=s_arready & ~ar_done; ar_done sets on AR handshake. x_rvalid=s_rvalid, x_rdata/x_rresp=s_*, s_rready=x_rready. R handshake → IDLE, ar_done cleared. The non-granted master sees all readies/valids 0.
- WR_LSU: AW and W forwarded independently, each gated by its own done flag (aw_done, w_done); either order or same cycle allowed. B channel forwarded once both done; B handshake → IDLE, flags cleared.
- rresp/bresp passed through unmodified; error responses still end the transaction.
- Outputs not belonging to the active state drive 0 (data buses may be 0 or don't-care; valids/readies strictly 0).
- Simultaneous lsu_awvalid and lsu_arvalid: write wins; read served next arbitration.
- A master deasserting valid before handshake is a protocol error; no recovery required beyond reset.
- No combinational path from a master valid to that master's ready except through slave ready.

Optional Feature:
ARB_RR_EN: when defined, IDLE arbitration between IFU and LSU uses a 1-bit last-grant pointer: on contention the master not granted last wins (LSU write still beats LSU read internally); pointer updates on transaction completion, resets to IFU-last. When undefined, fixed priority LSU write > LSU read > IFU read.

Test Plan:
- IFU read alone: ifu_araddr=0x8000_0000, slave arready after 2 cycles, rdata=0x0000_0413 → ifu_rvalid with 0x0000_0413, rresp=0, state back to IDLE, lsu_* valids stay 0.
- Contention: ifu_arvalid and lsu_arvalid same cycle (lsu addr 0x8000_0100) → slave sees 0x8000_0100 first; IFU AR accepted only after LSU R handshake (with ARB_RR_EN and IFU-last pointer: same; repeat contention → IFU granted next).
- Store with W before AW: lsu_wvalid 2 cycles ahead of awvalid, wdata=0xDEAD_BEEF, wstrb=3'b100 → s_wdata/s_wstrb match, bvalid forwarded only after both handshakes, lsu_bresp=0.
- AW and AR from LSU simultaneous → WR_LSU entered first, read served after B handshake.
- Slave rresp=2'b10 on IFU read → ifu_rresp=2'b10, arbiter returns to IDLE normally.
- rst asserted in RD_LSU after AR handshake → next cycle IDLE, s_rready=0, lsu_arready=0, arb_busy=0.
